// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - TAP state encodings, instruction opcodes and DR select decode
package jtag_pkg;

    localparam logic [3:0] TEST_LOGIC_RESET = 4'hF;
    localparam logic [3:0] RUN_TEST_IDLE    = 4'hC;
    localparam logic [3:0] SELECT_DR        = 4'h7;
    localparam logic [3:0] CAPTURE_DR       = 4'h6;
    localparam logic [3:0] SHIFT_DR         = 4'h2;
    localparam logic [3:0] EXIT1_DR         = 4'h1;
    localparam logic [3:0] PAUSE_DR         = 4'h3;
    localparam logic [3:0] EXIT2_DR         = 4'h0;
    localparam logic [3:0] UPDATE_DR        = 4'h5;
    localparam logic [3:0] SELECT_IR        = 4'h4;
    localparam logic [3:0] CAPTURE_IR       = 4'hE;
    localparam logic [3:0] SHIFT_IR         = 4'hA;
    localparam logic [3:0] EXIT1_IR         = 4'h9;
    localparam logic [3:0] PAUSE_IR         = 4'hB;
    localparam logic [3:0] EXIT2_IR         = 4'h8;
    localparam logic [3:0] UPDATE_IR        = 4'hD;

    localparam logic [3:0] IDCODE  = 4'h1;
    localparam logic [3:0] USER_WR = 4'h2;
    localparam logic [3:0] USER_RD = 4'h3;
    localparam logic [3:0] BYPASS  = 4'hF;

    typedef enum logic [1:0] {
        DR_SEL_BYPASS,
        DR_SEL_IDCODE,
        DR_SEL_USER
    } dr_sel_e;

    // Unknown opcodes fall back to BYPASS so the chain length stays defined.
    function automatic dr_sel_e decode_dr(input logic [3:0] op);
        case (op)
            IDCODE:           return DR_SEL_IDCODE;
            USER_WR, USER_RD: return DR_SEL_USER;
            default:          return DR_SEL_BYPASS;
        endcase
    endfunction

endpackage

// File: rtl/jtag_shift_reg.sv
// rtl/jtag_shift_reg.sv - capture/shift register, shifts right with serial input at MSB
module jtag_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_capture,
    input  logic             i_shift,
    input  logic             i_sdi,
    input  logic [WIDTH-1:0] i_cap_val,
    output logic             o_sdo,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr <= '0;
        end else if (i_capture) begin
            r_sr <= i_cap_val;
        end else if (i_shift) begin
            r_sr <= WIDTH'({i_sdi, r_sr} >> 1);
        end
    end

    assign o_sdo  = r_sr[0];
    assign o_data = r_sr;

endmodule

// File: rtl/jtag_reg_bank.sv
// rtl/jtag_reg_bank.sv - JTAG IR plus IDCODE/BYPASS/user DR bank driven by TAP state
module jtag_reg_bank
    import jtag_pkg::*;
#(
    parameter int              IR_W       = 4,
    parameter int              DR_W       = 32,
    parameter logic [31:0]     IDCODE_VAL = 32'h1234_5001,
    parameter logic [IR_W-1:0] IR_CAPTURE = 4'b0101
) (
    input  logic            TCK,
    input  logic            TRST,
    input  logic            TDI,
    input  logic [3:0]      state,
    input  logic [DR_W-1:0] user_din,
    output logic            TDO,
    output logic            TDO_EN,
    output logic [IR_W-1:0] ir,
    output logic [DR_W-1:0] user_dout,
    output logic            user_upd,
    output logic            user_cap
);

    logic [IR_W-1:0] r_ir;
    logic [DR_W-1:0] r_user_dout;
    logic            r_user_upd;
    logic            r_user_cap;
    logic            r_bypass;

    dr_sel_e         w_dr_sel;
    logic            w_cap_dr;
    logic            w_shift_dr;
    logic            w_ir_sdo;
    logic [IR_W-1:0] w_ir_sr;
    logic            w_idcode_sdo;
    logic [31:0]     w_idcode_data_unused;
    logic            w_user_sdo;
    logic [DR_W-1:0] w_user_sr;
    logic            w_tdo;

    // ir only changes at UPDATE_IR/TLR, so a DR scan always sees its capture-time select.
    assign w_dr_sel   = decode_dr(r_ir);
    assign w_cap_dr   = (state == CAPTURE_DR);
    assign w_shift_dr = (state == SHIFT_DR);

    jtag_shift_reg #(.WIDTH(IR_W)) u_ir_sr (
        .clk       (TCK),
        .rst       (TRST),
        .i_capture (state == CAPTURE_IR),
        .i_shift   (state == SHIFT_IR),
        .i_sdi     (TDI),
        .i_cap_val (IR_CAPTURE),
        .o_sdo     (w_ir_sdo),
        .o_data    (w_ir_sr)
    );

    jtag_shift_reg #(.WIDTH(32)) u_idcode_sr (
        .clk       (TCK),
        .rst       (TRST),
        .i_capture (w_cap_dr && (w_dr_sel == DR_SEL_IDCODE)),
        .i_shift   (w_shift_dr && (w_dr_sel == DR_SEL_IDCODE)),
        .i_sdi     (TDI),
        .i_cap_val (IDCODE_VAL),
        .o_sdo     (w_idcode_sdo),
        .o_data    (w_idcode_data_unused)
    );

    jtag_shift_reg #(.WIDTH(DR_W)) u_user_sr (
        .clk       (TCK),
        .rst       (TRST),
        .i_capture (w_cap_dr && (w_dr_sel == DR_SEL_USER)),
        .i_shift   (w_shift_dr && (w_dr_sel == DR_SEL_USER)),
        .i_sdi     (TDI),
        .i_cap_val (user_din),
        .o_sdo     (w_user_sdo),
        .o_data    (w_user_sr)
    );

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            r_bypass <= 1'b0;
        end else if (w_dr_sel == DR_SEL_BYPASS) begin
            if (w_cap_dr) begin
                r_bypass <= 1'b0;
            end else if (w_shift_dr) begin
                r_bypass <= TDI;
            end
        end
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            r_ir        <= IDCODE;
            r_user_dout <= '0;
            r_user_upd  <= 1'b0;
            r_user_cap  <= 1'b0;
        end else begin
            r_user_cap <= w_cap_dr && (w_dr_sel == DR_SEL_USER);
            r_user_upd <= (state == UPDATE_DR) && (r_ir == USER_WR);
            if ((state == UPDATE_DR) && (r_ir == USER_WR)) begin
                r_user_dout <= w_user_sr;
            end
            if (state == TEST_LOGIC_RESET) begin
                r_ir <= IDCODE;
            end else if (state == UPDATE_IR) begin
                r_ir <= w_ir_sr;
            end
        end
    end

    always_comb begin
        w_tdo = 1'b0;
        if (state == SHIFT_IR) begin
            w_tdo = w_ir_sdo;
        end else if (state == SHIFT_DR) begin
            case (w_dr_sel)
                DR_SEL_IDCODE: w_tdo = w_idcode_sdo;
                DR_SEL_USER:   w_tdo = w_user_sdo;
                default:       w_tdo = r_bypass;
            endcase
        end
    end

    assign TDO       = w_tdo;
    assign TDO_EN    = (state == SHIFT_IR) || (state == SHIFT_DR);
    assign ir        = r_ir;
    assign user_dout = r_user_dout;
    assign user_upd  = r_user_upd;
    assign user_cap  = r_user_cap;

endmodule

// File: tb/tb_jtag_reg_bank.sv
// tb/tb_jtag_reg_bank.sv - directed and randomized scans of jtag_reg_bank against a scan-level model
module tb_jtag_reg_bank;
    import jtag_pkg::*;

    localparam int DR_W = 32;

    logic            TCK;
    logic            TRST;
    logic            TDI;
    logic [3:0]      state;
    logic [DR_W-1:0] user_din;
    logic            TDO;
    logic            TDO_EN;
    logic [3:0]      ir;
    logic [DR_W-1:0] user_dout;
    logic            user_upd;
    logic            user_cap;

    int n_tests = 0;
    int n_fail  = 0;

    logic            r_tdo;
    logic            r_tdo_en;
    logic [3:0]      m_ir;
    logic [DR_W-1:0] m_dout;

    jtag_reg_bank #(
        .IR_W       (4),
        .DR_W       (DR_W),
        .IDCODE_VAL (32'h1234_5001),
        .IR_CAPTURE (4'b0101)
    ) dut (
        .TCK       (TCK),
        .TRST      (TRST),
        .TDI       (TDI),
        .state     (state),
        .user_din  (user_din),
        .TDO       (TDO),
        .TDO_EN    (TDO_EN),
        .ir        (ir),
        .user_dout (user_dout),
        .user_upd  (user_upd),
        .user_cap  (user_cap)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one TAP state for one TCK cycle; TDO is sampled on the falling edge.
    task automatic tick(input logic [3:0] st, input logic d);
        state = st;
        TDI   = d;
        @(negedge TCK);
        r_tdo    = TDO;
        r_tdo_en = TDO_EN;
        @(posedge TCK);
        #1;
    endtask

    // Model: a scan emits {tdi, captured} LSB-first; the register keeps the next width bits.
    task automatic scan_ir(input int n, input logic [63:0] tdi, output logic [63:0] got);
        logic [127:0] big;
        logic [127:0] rest;
        logic [63:0]  mask;
        big  = ({64'd0, tdi} << 4) | 128'(4'b0101);
        mask = (64'd1 << n) - 64'd1;
        got  = '0;
        tick(SELECT_DR, 1'b0);
        tick(SELECT_IR, 1'b0);
        tick(CAPTURE_IR, 1'b0);
        for (int i = 0; i < n; i++) begin
            tick(SHIFT_IR, tdi[i]);
            got[i] = r_tdo;
            if (i == 0) check("ir_tdo_en", 64'(r_tdo_en), 64'd1);
        end
        check("ir_tdo_seq", got, big[63:0] & mask);
        tick(EXIT1_IR, 1'b0);
        check("ir_hold_before_update", 64'(ir), 64'(m_ir));
        tick(UPDATE_IR, 1'b0);
        rest = big >> n;
        m_ir = rest[3:0];
        check("ir_after_update", 64'(ir), 64'(m_ir));
        tick(RUN_TEST_IDLE, 1'b0);
    endtask

    task automatic scan_dr(input int n, input logic [63:0] tdi, input logic [DR_W-1:0] din,
                           input bit pause, output logic [63:0] got);
        logic [127:0] big;
        logic [127:0] rest;
        logic [63:0]  mask;
        logic [63:0]  cap;
        int           w;
        bit           is_user;
        is_user = (m_ir == 4'h2) || (m_ir == 4'h3);
        if (m_ir == 4'h1) begin
            w = 32; cap = 64'h1234_5001;
        end else if (is_user) begin
            w = DR_W; cap = 64'(din);
        end else begin
            w = 1; cap = 64'd0;
        end
        big      = ({64'd0, tdi} << w) | {64'd0, cap};
        mask     = (64'd1 << n) - 64'd1;
        got      = '0;
        user_din = din;
        tick(SELECT_DR, 1'b0);
        tick(CAPTURE_DR, 1'b0);
        check("user_cap_pulse", 64'(user_cap), 64'(is_user));
        for (int i = 0; i < n; i++) begin
            if (pause && i == n / 2) begin
                tick(EXIT1_DR, 1'($urandom));
                check("exit_tdo", 64'(r_tdo), 64'd0);
                tick(PAUSE_DR, 1'($urandom));
                tick(PAUSE_DR, 1'($urandom));
                check("pause_tdo_en", 64'(r_tdo_en), 64'd0);
                tick(EXIT2_DR, 1'($urandom));
            end
            tick(SHIFT_DR, tdi[i]);
            got[i] = r_tdo;
            if (i == 0) check("user_cap_clear", 64'(user_cap), 64'd0);
        end
        check("dr_tdo_seq", got, big[63:0] & mask);
        tick(EXIT1_DR, 1'b0);
        tick(UPDATE_DR, 1'b0);
        if (m_ir == 4'h2) begin
            rest   = big >> n;
            m_dout = rest[DR_W-1:0];
        end
        check("user_upd_pulse", 64'(user_upd), 64'(m_ir == 4'h2));
        check("user_dout", 64'(user_dout), 64'(m_dout));
        tick(RUN_TEST_IDLE, 1'b0);
        check("user_upd_clear", 64'(user_upd), 64'd0);
    endtask

    initial begin
        logic [63:0]     got;
        logic [63:0]     tdi;
        logic [3:0]      op;
        logic [DR_W-1:0] keep;
        int              n;

        TRST     = 1'b1;
        TDI      = 1'b0;
        state    = TEST_LOGIC_RESET;
        user_din = '0;
        m_ir     = 4'h1;
        m_dout   = '0;
        #12;
        check("rst_ir", 64'(ir), 64'h1);
        check("rst_user_dout", 64'(user_dout), 64'd0);
        check("rst_user_upd", 64'(user_upd), 64'd0);
        check("rst_user_cap", 64'(user_cap), 64'd0);
        check("rst_tdo", 64'(TDO), 64'd0);
        check("rst_tdo_en", 64'(TDO_EN), 64'd0);
        TRST = 1'b0;
        tick(TEST_LOGIC_RESET, 1'b0);
        tick(RUN_TEST_IDLE, 1'b0);

        scan_dr(32, 64'(32'hFFFF_FFFF), '0, 1'b0, got);
        check("idcode_value", got[31:0], 64'h1234_5001);

        scan_ir(4, 64'hF, got);
        scan_dr(4, 64'b1101, '0, 1'b0, got);
        check("bypass_delay", got[3:0], 64'b1010);

        scan_ir(4, 64'h2, got);
        check("ir_capture_out", got[3:0], 64'b0101);
        check("ir_user_wr", 64'(ir), 64'h2);

        scan_dr(32, 64'(32'hDEAD_BEEF), DR_W'($urandom), 1'b0, got);
        check("user_wr_dout", 64'(user_dout), 64'hDEAD_BEEF);

        scan_ir(4, 64'h3, got);
        scan_dr(32, 64'($urandom), 32'hA5A5_0F0F, 1'b0, got);
        check("user_rd_tdo", got[31:0], 64'hA5A5_0F0F);
        check("user_rd_keeps_dout", 64'(user_dout), 64'hDEAD_BEEF);

        scan_ir(4, 64'h7, got);
        scan_dr(6, 64'($urandom), '0, 1'b1, got);
        tick(SELECT_DR, 1'b0);
        tick(SELECT_IR, 1'b0);
        tick(TEST_LOGIC_RESET, 1'b0);
        m_ir = 4'h1;
        check("tlr_ir", 64'(ir), 64'h1);
        tick(RUN_TEST_IDLE, 1'b0);

        scan_ir(4, 64'h2, got);
        keep = DR_W'($urandom) | 32'h1;
        scan_dr(32, 64'(keep), '0, 1'b0, got);
        check("user_wr_before_trst", 64'(user_dout), 64'(keep));
        tick(SELECT_DR, 1'b0);
        tick(CAPTURE_DR, 1'b0);
        for (int i = 0; i < 10; i++) tick(SHIFT_DR, 1'($urandom));
        TRST = 1'b1;
        #1;
        m_ir   = 4'h1;
        m_dout = '0;
        check("trst_mid_ir", 64'(ir), 64'h1);
        check("trst_mid_dout", 64'(user_dout), 64'd0);
        check("trst_mid_tdo", 64'(TDO), 64'd0);
        #2;
        TRST = 1'b0;
        tick(RUN_TEST_IDLE, 1'b0);
        check("post_trst_ir", 64'(ir), 64'h1);

        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 4))
                0:       op = 4'h1;
                1:       op = 4'h2;
                2:       op = 4'h3;
                3:       op = 4'hF;
                default: op = 4'($urandom);
            endcase
            n   = 4 + int'($urandom_range(0, 3));
            tdi = {$urandom, $urandom};
            tdi[n-4 +: 4] = op;
            scan_ir(n, tdi, got);
            check("rand_ir_loaded", 64'(ir), 64'(op));
            scan_dr(int'($urandom_range(1, 40)), {$urandom, $urandom}, DR_W'($urandom),
                    1'($urandom), got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_reg_bank.md
Name: jtag_reg_bank

Overview:
Instruction register plus data-register bank fed directly by the TAP controller's `state[3:0]` output. It decodes the controller's state encoding to perform capture, shift and update on the IR and the selected DR. The DR is one of IDCODE, BYPASS or a user data register. It drives TDO back to the JTAG pin and exposes a parallel user DR port to core logic.

Parameters:
IR_W, 4, instruction register width (fixed encodings below assume 4)
DR_W, 32, user data register width (>=2)
IDCODE_VAL, 32'h1234_5001, IDCODE value; bit0 must be 1
IR_CAPTURE, 4'b0101, value loaded into IR shift stage in CAPTURE_IR; bits[1:0] must be 2'b01

Ports:
TCK  input  1  JTAG clock; all state changes on posedge
TRST  input  1  asynchronous, active-high reset
TDI  input  1  serial data in
state  input  4  TAP state from controller (encodings in package)
user_din  input  DR_W  parallel value captured into user DR
TDO  output  1  serial data out
TDO_EN  output  1  high while in SHIFT_IR or SHIFT_DR
ir  output  IR_W  current (updated) instruction
user_dout  output  DR_W  last updated user DR value
user_upd  output  1  one-cycle pulse after USER_WR update
user_cap  output  1  one-cycle pulse after USER_RD/USER_WR capture

Behaviour:
- Reset (TRST=1, async): `ir`=IDCODE (4'h1); ir_sr=0; idcode_sr=0; bypass_sr=0; user_sr=0; `user_dout`=0; `user_upd`=0; `user_cap`=0.
- TEST_LOGIC_RESET (4'hF) seen on posedge TCK: `ir` <= IDCODE synchronously. Shift registers hold.
- Instructions:
  - 4'h1 IDCODE
  - 4'h2 USER_WR
  - 4'h3 USER_RD
  - 4'hF BYPASS
  - any other value selects BYPASS
- DR select is decoded from `ir` combinationally.
- CAPTURE_IR (4'hE): ir_sr <= IR_CAPTURE.
- SHIFT_IR (4'hA): ir_sr <= {TDI, ir_sr[IR_W-1:1]}.
- UPDATE_IR (4'hD): `ir` <= ir_sr.
- CAPTURE_DR (4'h6), by selected DR:
  - IDCODE: idcode_sr <= IDCODE_VAL.
  - BYPASS: bypass_sr <= 0.
  - USER_RD/USER_WR: user_sr <= `user_din`; `user_cap` <= 1 for one cycle.
- SHIFT_DR (4'h2): the selected register only shifts right with TDI into the MSB. BYPASS is a 1-bit register.
- UPDATE_DR (4'h5): only when `ir`==USER_WR, `user_dout` <= user_sr and `user_upd` <= 1 for exactly one cycle. The other instructions have no update effect.
- `user_upd` and `user_cap` are deasserted on every posedge where their condition is false.
- TDO is combinational:
  - SHIFT_IR: ir_sr[0].
  - SHIFT_DR: LSB of the selected DR shift register.
  - Otherwise: 0.
- TDO_EN = (state==4'hA) || (state==4'h2).
- Latency:
  - Captured bit 0 appears on TDO in the SHIFT state's first cycle.
  - Each posedge in SHIFT presents the next bit.
- Pause/Exit states (4'h1, 4'h3, 4'h0, 4'h9, 4'hB, 4'h8): all registers hold.
- A `state` code not listed above: all registers hold.
- Instruction change only takes effect at UPDATE_IR. A DR scan in progress always uses the `ir` value in force at its CAPTURE_DR.
- Reset mid-scan: all registers return to reset values immediately. Partially shifted data is discarded and `user_dout` clears.
- Shift length beyond register width: TDI data passes through. After N>width shifts the register holds the last `width` TDI bits, LSB oldest.

Decomposition:
- Package `jtag_pkg` holds:
  - the 16 TAP state localparams (4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0, 4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD), shared with the TAP controller;
  - the instruction opcode constants IDCODE, USER_WR, USER_RD and BYPASS.
- One sub-module is natural: `jtag_shift_reg` (parameterised WIDTH, capture/shift/enable, LSB out), instantiated for the IR, IDCODE and user DR.
- BYPASS is inline.

Test Plan:
1. Assert TRST, release, go to SHIFT_DR via RTI and SELECT_DR, shift 32 bits -> TDO sequence LSB-first equals 32'h1234_5001; `ir`=4'h1.
2. Shift IR 4'hF (TDI 1,1,1,1), UPDATE_IR, then DR scan of 4 bits with TDI=1,0,1,1 -> TDO=0,1,0,1 (one-bit delay through BYPASS).
3. During the IR shift of 4'h2, observe TDO -> 1,0,1,0 (IR_CAPTURE LSB first). After UPDATE_IR, `ir`=4'h2.
4. USER_WR: shift 32'hDEAD_BEEF LSB-first, UPDATE_DR -> `user_dout`=32'hDEAD_BEEF, `user_upd` high exactly one TCK cycle.
5. USER_RD with `user_din`=32'hA5A5_0F0F: CAPTURE_DR -> `user_cap` pulse. Shift 32 -> TDO yields 32'hA5A5_0F0F. UPDATE_DR -> `user_upd` stays 0 and `user_dout` unchanged.
6. Load IR 4'h7 (undefined) -> DR scan behaves as BYPASS. Next, 5 posedges with TMS=1 into TEST_LOGIC_RESET -> `ir`=4'h1. Next, TRST pulse mid USER_WR shift -> `user_dout`=0 and `ir`=4'h1 immediately.
